// File: rtl/hilo_mult_unit_if.sv
// Issue/result bundle between ALU control and the HI/LO multiply unit.
interface hilo_mult_unit_if;
    logic        Start;
    logic [4:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MthiEn;
    logic        MtloEn;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MulLo;

    modport master (
        output Start, ALUOp, A, B, MthiEn, MtloEn, Flush,
        input  Busy, Done, Stall, HI, LO, MulLo
    );

    modport slave (
        input  Start, ALUOp, A, B, MthiEn, MtloEn, Flush,
        output Busy, Done, Stall, HI, LO, MulLo
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Iterative 32x32 shift-add multiply / multiply-accumulate unit with
// architectural HI/LO registers and a registered low word for mul.
module hilo_mult_unit (
    input  logic             Clk,
    input  logic             Reset,
    hilo_mult_unit_if.slave  bus
);
    localparam logic [4:0] OP_MULTU = 5'd26;
    localparam logic [4:0] OP_MSUB  = 5'd29;
    localparam logic [4:0] OP_MADD  = 5'd30;
    localparam logic [4:0] OP_MUL   = 5'd31;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t      state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] product_q, product_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mullo_q, mullo_d;
    logic        done_q, done_d;

    logic        start_ok;
    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] signed_p;

    // Only the four multiply-class opcodes launch an operation.
    assign start_ok  = bus.Start && (bus.ALUOp == OP_MULTU || bus.ALUOp == OP_MSUB ||
                                     bus.ALUOp == OP_MADD  || bus.ALUOp == OP_MUL);
    assign op_signed = (bus.ALUOp != OP_MULTU);
    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign abs_a     = bus.A[31] ? (32'd0 - bus.A) : bus.A;
    assign abs_b     = bus.B[31] ? (32'd0 - bus.B) : bus.B;
    assign signed_p  = neg_q ? (64'd0 - product_q) : product_q;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; Flush aborts from either busy state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_ok) state_d = S_RUN;
            S_RUN:    if (bus.Flush) state_d = S_IDLE;
                      else if (count_q == 6'd31) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; Stall is purely combinational.
    always_comb begin
        bus.Busy  = (state_q != S_IDLE);
        bus.Stall = (state_q != S_IDLE) &&
                    ((bus.ALUOp >= 5'd26) || bus.MthiEn || bus.MtloEn);
    end

    // Datapath next values: operand latch, shift-add step, HI/LO writeback.
    always_comb begin
        op_d      = op_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mullo_d   = mullo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.MthiEn) hi_d = bus.A;
                if (bus.MtloEn) lo_d = bus.A;
                if (start_ok) begin
                    op_d      = bus.ALUOp;
                    neg_d     = op_signed && (bus.A[31] ^ bus.B[31]);
                    mcand_d   = op_signed ? abs_a : bus.A;
                    mplier_d  = op_signed ? abs_b : bus.B;
                    product_d = '0;
                    count_d   = '0;
                end
            end
            S_RUN: begin
                if (!bus.Flush) begin
                    if (mplier_q[count_q[4:0]])
                        product_d = product_q + ({32'd0, mcand_q} << count_q);
                    count_d = count_q + 6'd1;
                end
            end
            S_FINISH: begin
                if (!bus.Flush) begin
                    done_d = 1'b1;
                    case (op_q)
                        OP_MULTU: {hi_d, lo_d} = signed_p;
                        OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + signed_p;
                        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - signed_p;
                        default:  mullo_d = signed_p[31:0];
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mullo_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            op_q      <= op_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mullo_q   <= mullo_d;
            done_q    <= done_d;
        end
    end

    assign bus.Done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.MulLo = mullo_q;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit.
module tb_hilo_mult_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   saw_done;

    hilo_mult_unit_if bus ();

    hilo_mult_unit u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.Start  = 1'b0;
        bus.ALUOp  = 5'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        bus.MthiEn = 1'b0;
        bus.MtloEn = 1'b0;
        bus.Flush  = 1'b0;
    endtask

    // Issue one op (edge n), then run the 33 further edges to completion.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        tick();
        clear_inputs();
        repeat (33) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        #12;
        check("rst_busy",  bus.Busy,  1'b0);
        check("rst_done",  bus.Done,  1'b0);
        check("rst_hi",    bus.HI,    32'd0);
        check("rst_lo",    bus.LO,    32'd0);
        check("rst_mullo", bus.MulLo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // multu 0xFFFFFFFF * 0xFFFFFFFF with exact timing
        bus.Start = 1'b1; bus.ALUOp = 5'd26; bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF;
        tick();
        clear_inputs();
        check("t1_busy_n", bus.Busy, 1'b1);
        repeat (32) tick();
        check("t1_busy_n32", bus.Busy, 1'b1);
        check("t1_done_n32", bus.Done, 1'b0);
        check("t1_hi_n32",   bus.HI,   32'd0);
        tick();
        check("t1_done", bus.Done, 1'b1);
        check("t1_busy", bus.Busy, 1'b0);
        check("t1_hi",   bus.HI,   32'hFFFFFFFE);
        check("t1_lo",   bus.LO,   32'h00000001);
        tick();
        check("t1_done_clr", bus.Done, 1'b0);

        // mul -3 * 7 leaves HI/LO alone
        bus.MthiEn = 1'b1; bus.A = 32'h1234; tick(); clear_inputs();
        bus.MtloEn = 1'b1; bus.A = 32'h5678; tick(); clear_inputs();
        run_op(5'd31, 32'hFFFFFFFD, 32'd7);
        check("t2_done",  bus.Done,  1'b1);
        check("t2_mullo", bus.MulLo, 32'hFFFFFFEB);
        check("t2_hi",    bus.HI,    32'h1234);
        check("t2_lo",    bus.LO,    32'h5678);

        // both move strobes at once, then madd / msub
        bus.MthiEn = 1'b1; bus.MtloEn = 1'b1; bus.A = 32'd0; tick(); clear_inputs();
        check("t3_mv_hi", bus.HI, 32'd0);
        check("t3_mv_lo", bus.LO, 32'd0);
        bus.MtloEn = 1'b1; bus.A = 32'd10; tick(); clear_inputs();
        check("t3_mtlo", bus.LO, 32'd10);
        run_op(5'd30, 32'hFFFFFFFE, 32'd3);
        check("t3_madd_hi", bus.HI, 32'd0);
        check("t3_madd_lo", bus.LO, 32'd4);
        run_op(5'd29, 32'd2, 32'd3);
        check("t3_msub_hi", bus.HI, 32'hFFFFFFFF);
        check("t3_msub_lo", bus.LO, 32'hFFFFFFFE);

        // madd of two most-negative values from zero
        bus.MthiEn = 1'b1; bus.MtloEn = 1'b1; bus.A = 32'd0; tick(); clear_inputs();
        run_op(5'd30, 32'h80000000, 32'h80000000);
        check("t4_hi", bus.HI, 32'h40000000);
        check("t4_lo", bus.LO, 32'd0);

        // mtlo on the same edge as Start: madd accumulates onto the new LO
        bus.Start = 1'b1; bus.ALUOp = 5'd30; bus.A = 32'd3; bus.B = 32'd3; bus.MtloEn = 1'b1;
        tick();
        clear_inputs();
        repeat (33) tick();
        check("t4b_hi", bus.HI, 32'h40000000);
        check("t4b_lo", bus.LO, 32'h0000000C);

        // Stall decode and ignored inputs while busy
        bus.ALUOp = 5'd27; #1;
        check("t5_stall_idle", bus.Stall, 1'b0);
        bus.Start = 1'b1; bus.ALUOp = 5'd26; bus.A = 32'd3; bus.B = 32'd5;
        tick();
        bus.Start = 1'b1; bus.ALUOp = 5'd31; bus.A = 32'd7; bus.B = 32'd7; #1;
        check("t5_stall_31", bus.Stall, 1'b1);
        bus.ALUOp = 5'd27; #1;
        check("t5_stall_27", bus.Stall, 1'b1);
        bus.ALUOp = 5'd2; #1;
        check("t5_stall_2", bus.Stall, 1'b0);
        bus.MthiEn = 1'b1; bus.A = 32'hDEAD; #1;
        check("t5_stall_mthi", bus.Stall, 1'b1);
        bus.Start = 1'b1; bus.ALUOp = 5'd31;
        tick();
        clear_inputs();
        check("t5_mthi_ignored", bus.HI, 32'h40000000);
        repeat (31) tick();
        check("t5_done_n32", bus.Done, 1'b0);
        tick();
        check("t5_done", bus.Done,  1'b1);
        check("t5_hi",   bus.HI,    32'd0);
        check("t5_lo",   bus.LO,    32'd15);
        check("t5_mullo", bus.MulLo, 32'hFFFFFFEB);
        tick();

        // Flush at RUN cycle 10
        bus.Start = 1'b1; bus.ALUOp = 5'd30; bus.A = 32'd5; bus.B = 32'd5;
        tick();
        clear_inputs();
        repeat (10) tick();
        bus.Flush = 1'b1;
        tick();
        clear_inputs();
        check("t6_busy", bus.Busy, 1'b0);
        check("t6_hi",   bus.HI,   32'd0);
        check("t6_lo",   bus.LO,   32'd15);
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.Done) saw_done = 1'b1;
            tick();
        end
        check("t6_no_done", saw_done, 1'b0);
        check("t6_lo_after", bus.LO, 32'd15);

        // asynchronous reset mid-RUN
        bus.Start = 1'b1; bus.ALUOp = 5'd26; bus.A = 32'd9; bus.B = 32'd9;
        tick();
        clear_inputs();
        repeat (5) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t7_hi",    bus.HI,    32'd0);
        check("t7_lo",    bus.LO,    32'd0);
        check("t7_mullo", bus.MulLo, 32'd0);
        check("t7_busy",  bus.Busy,  1'b0);
        check("t7_done",  bus.Done,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("t7_busy_after", bus.Busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
